ats21_cmd_arb: RTL and testbench
================================

# ats21_cmd_arb

Command front-end for the ats21 alarm/timer core. Assembles 32-bit commands from the two 16-bit control ports (ctrlA, ctrlB) over a two-beat req/ready load sequence. Drops no-op and illegal opcodes. Arbitrates the surviving A and B commands round-robin onto a single valid/ready issue interface feeding the core's command decoder.

## Interface
- LO_TIMEOUT, default 8: max idle cycles allowed between upper and lower beats; range 1..255.
- clk  input  1  sole clock; all state on rising edge.
- reset  input  1  asynchronous, active-low; clears all state immediately.
- req  input  1  load strobe shared by both ports; sampled only when ready=1.
- ctrlA  input  16  port A half-command.
- ctrlB  input  16  port B half-command.
- ready  output  1  loader can accept a beat this cycle.
- stat  output  2  stat[0]/stat[1]: one-cycle pulse after a port A/B command is accepted downstream.
- cmd_valid  output  1  issue register holds a command.
- cmd_data  output  32  command word {opcode[31:29], fields[28:0]}.
- cmd_src  output  1  0 = port A, 1 = port B.
- cmd_ready  input  1  core accepts cmd_data this cycle.
- err_illegal  output  2  one-cycle pulse per port: opcode 3'b100 received and dropped.
- err_timeout  output  1  one-cycle pulse: lower beat missing, upper half discarded.

## Operation
- Loader FSM, states HI (expect upper halves) and LO (expect lower halves). Reset state is HI.
- HI:
  - ready = !pendA && !pendB.
  - req && ready: capture ctrlA into upA[31:16] and ctrlB into upB[31:16]; go to LO; clear idle counter.
- LO:
  - ready = 1.
  - req: form cmdA = {upA, ctrlA} and cmdB = {upB, ctrlB}; go to HI.
  - Per port, by opcode [31:29]:
    - 000: drop silently.
    - 100: drop and pulse err_illegal[port].
    - Anything else: set pend<port> and store the command.
  - !req: increment idle counter. When it reaches LO_TIMEOUT, go to HI, discard upA/upB, and pulse err_timeout. No pend bits change.
- Issue register (cmd_valid, cmd_data, cmd_src):
  - Loads when empty, or when cmd_valid && cmd_ready (back-to-back issue allowed).
  - Loading clears the selected pend bit.
- Arbitration when loading:
  - Only one pending: take it.
  - Both pending: take the port not granted last, then update last_grant.
  - Reset value of last_grant is B, so A wins the first tie.
- cmd_data and cmd_src are held stable while cmd_valid && !cmd_ready.
- stat[src] pulses high for exactly the cycle after the accepting edge (cmd_valid && cmd_ready). The stat bits are otherwise 0.

## Timing
- Reset values: ready=1, stat=2'b00, cmd_valid=0, cmd_data=0, cmd_src=0, err_illegal=2'b00, err_timeout=0, state=HI, pendA=pendB=0, last_grant=B, idle counter=0.
- Reset asserted mid-sequence discards partial upper halves, pending commands and the issue register with no pulses. The first edge after deassertion behaves as HI.
- Latency:
  - Upper beat at edge k, lower beat at edge k+1: pend set after k+1; cmd_valid=1 after edge k+2 (issue register idle).
  - Downstream accept at edge m: stat pulse in cycle m+1. The next pending command is in cmd_valid after edge m.
- err_illegal and err_timeout are registered. They pulse in the cycle after the causing edge.
- A req with ready=0 is ignored: no capture and no state change.
- Timeout count: with the upper beat at edge k and no req afterwards, err_timeout pulses after edge k+LO_TIMEOUT and the state is HI. A req arriving exactly at edge k+LO_TIMEOUT is honored as the lower beat; the timeout does not fire.
- Throughput: at most one issued command per cycle, and at most two commands per load pair.

## Test plan
- Reset then single A command: HI beat ctrlA=16'h2A00, ctrlB=0; LO beat ctrlA=16'h0010, ctrlB=0; cmd_ready=1 -> cmd_valid for one cycle with cmd_data=32'h2A000010, cmd_src=0; stat=2'b01 one cycle later; no B issue.
- Simultaneous A and B with cmd_ready=1: A=32'h2200_0005, B=32'hE080_0000 -> A issued first, B on the next cycle. A second identical pair -> B first, then A (round-robin).
- Backpressure: cmd_ready=0 for 5 cycles while both are pending -> cmd_data stable, ready=0 in HI, new req ignored. After cmd_ready=1 both drain and ready returns to 1.
- Illegal and no-op: A opcode 100, B opcode 000 -> err_illegal=2'b01 for one cycle, no cmd_valid, ready stays 1.
- Timeout: LO_TIMEOUT=8, upper beat, then req low for 8 cycles -> err_timeout pulse, state HI. The next req is treated as a new upper beat.
- Asynchronous reset asserted while cmd_valid=1 and in LO -> all outputs take reset values immediately, with no stat pulse.

Source files
------------

// File: rtl/ats21_cmd_arb.sv
// Command front-end: pairs two 16-bit beats per port into 32-bit commands,
// filters no-op/illegal opcodes and round-robins ports A/B onto one issue slot.
module ats21_cmd_arb #(
    parameter int unsigned LO_TIMEOUT = 8
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        req_i,
    input  logic [15:0] ctrl_a_i,
    input  logic [15:0] ctrl_b_i,
    output logic        ready_o,
    output logic [1:0]  stat_o,
    output logic        cmd_valid_o,
    output logic [31:0] cmd_data_o,
    output logic        cmd_src_o,
    input  logic        cmd_ready_i,
    output logic [1:0]  err_illegal_o,
    output logic        err_timeout_o,
    output logic        dbg_state_o
);
    typedef enum logic {ST_HI = 1'b0, ST_LO = 1'b1} state_e;

    localparam logic [2:0] OP_NOP      = 3'b000;
    localparam logic [2:0] OP_ILL      = 3'b100;
    localparam logic [7:0] TIMEOUT_CNT = 8'(LO_TIMEOUT);

    state_e      state_q, state_d;
    logic [7:0]  idle_q, idle_d;
    logic [15:0] up_a_q, up_a_d, up_b_q, up_b_d;
    logic        pend_a_q, pend_a_d, pend_b_q, pend_b_d;
    logic [31:0] cmd_a_q, cmd_a_d, cmd_b_q, cmd_b_d;
    logic        cmd_valid_q, cmd_valid_d;
    logic [31:0] cmd_data_q, cmd_data_d;
    logic        cmd_src_q, cmd_src_d;
    logic        last_grant_q, last_grant_d;
    logic [1:0]  stat_q, stat_d;
    logic [1:0]  err_ill_q, err_ill_d;
    logic        err_to_q, err_to_d;
    logic        set_a, set_b, clr_a, clr_b;
    logic [31:0] word_a, word_b;
    logic        accept, issue_load;

    assign word_a     = {up_a_q, ctrl_a_i};
    assign word_b     = {up_b_q, ctrl_b_i};
    assign accept     = cmd_valid_q && cmd_ready_i;
    assign issue_load = !cmd_valid_q || cmd_ready_i;
    // Upper beats wait until both pending slots are free, so a lower beat never overwrites.
    assign ready_o    = (state_q == ST_HI) ? !(pend_a_q || pend_b_q) : 1'b1;

    always_comb begin
        state_d   = state_q;
        idle_d    = idle_q;
        up_a_d    = up_a_q;
        up_b_d    = up_b_q;
        cmd_a_d   = cmd_a_q;
        cmd_b_d   = cmd_b_q;
        set_a     = 1'b0;
        set_b     = 1'b0;
        err_ill_d = 2'b00;
        err_to_d  = 1'b0;
        case (state_q)
            ST_HI: begin
                if (req_i && ready_o) begin
                    up_a_d  = ctrl_a_i;
                    up_b_d  = ctrl_b_i;
                    idle_d  = 8'd0;
                    state_d = ST_LO;
                end
            end
            ST_LO: begin
                if (req_i) begin
                    state_d = ST_HI;
                    if (word_a[31:29] == OP_ILL) begin
                        err_ill_d[0] = 1'b1;
                    end else if (word_a[31:29] != OP_NOP) begin
                        set_a   = 1'b1;
                        cmd_a_d = word_a;
                    end
                    if (word_b[31:29] == OP_ILL) begin
                        err_ill_d[1] = 1'b1;
                    end else if (word_b[31:29] != OP_NOP) begin
                        set_b   = 1'b1;
                        cmd_b_d = word_b;
                    end
                end else begin
                    idle_d = idle_q + 8'd1;
                    if (idle_d == TIMEOUT_CNT) begin
                        state_d  = ST_HI;
                        err_to_d = 1'b1;
                        up_a_d   = 16'h0000;
                        up_b_d   = 16'h0000;
                    end
                end
            end
            default: state_d = ST_HI;
        endcase
    end

    // last_grant only moves on a real tie: 1 means B won the previous tie.
    always_comb begin
        cmd_valid_d  = cmd_valid_q;
        cmd_data_d   = cmd_data_q;
        cmd_src_d    = cmd_src_q;
        last_grant_d = last_grant_q;
        clr_a        = 1'b0;
        clr_b        = 1'b0;
        stat_d       = 2'b00;
        if (accept) begin
            stat_d = cmd_src_q ? 2'b10 : 2'b01;
        end
        if (issue_load) begin
            cmd_valid_d = pend_a_q || pend_b_q;
            if (pend_a_q && (!pend_b_q || last_grant_q)) begin
                cmd_data_d = cmd_a_q;
                cmd_src_d  = 1'b0;
                clr_a      = 1'b1;
                if (pend_b_q) begin
                    last_grant_d = 1'b0;
                end
            end else if (pend_b_q) begin
                cmd_data_d = cmd_b_q;
                cmd_src_d  = 1'b1;
                clr_b      = 1'b1;
                if (pend_a_q) begin
                    last_grant_d = 1'b1;
                end
            end
        end
    end

    assign pend_a_d = set_a || (pend_a_q && !clr_a);
    assign pend_b_d = set_b || (pend_b_q && !clr_b);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q      <= ST_HI;
            idle_q       <= 8'd0;
            up_a_q       <= 16'h0000;
            up_b_q       <= 16'h0000;
            pend_a_q     <= 1'b0;
            pend_b_q     <= 1'b0;
            cmd_a_q      <= 32'h0;
            cmd_b_q      <= 32'h0;
            cmd_valid_q  <= 1'b0;
            cmd_data_q   <= 32'h0;
            cmd_src_q    <= 1'b0;
            last_grant_q <= 1'b1;
            stat_q       <= 2'b00;
            err_ill_q    <= 2'b00;
            err_to_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            idle_q       <= idle_d;
            up_a_q       <= up_a_d;
            up_b_q       <= up_b_d;
            pend_a_q     <= pend_a_d;
            pend_b_q     <= pend_b_d;
            cmd_a_q      <= cmd_a_d;
            cmd_b_q      <= cmd_b_d;
            cmd_valid_q  <= cmd_valid_d;
            cmd_data_q   <= cmd_data_d;
            cmd_src_q    <= cmd_src_d;
            last_grant_q <= last_grant_d;
            stat_q       <= stat_d;
            err_ill_q    <= err_ill_d;
            err_to_q     <= err_to_d;
        end
    end

    assign stat_o        = stat_q;
    assign cmd_valid_o   = cmd_valid_q;
    assign cmd_data_o    = cmd_data_q;
    assign cmd_src_o     = cmd_src_q;
    assign err_illegal_o = err_ill_q;
    assign err_timeout_o = err_to_q;
    assign dbg_state_o   = state_q;
endmodule

// File: tb/tb_ats21_cmd_arb.sv
// Bench for ats21_cmd_arb: per-cycle comparison against a port-indexed model,
// plus literal expectations for the documented scenarios.
module tb_ats21_cmd_arb;
  localparam int LO_T = 8;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req = 1'b0;
  logic [15:0] ctrl_a = '0;
  logic [15:0] ctrl_b = '0;
  logic        cmd_ready = 1'b0;
  logic        ready_o;
  logic [1:0]  stat_o;
  logic        cmd_valid_o;
  logic [31:0] cmd_data_o;
  logic        cmd_src_o;
  logic [1:0]  err_illegal_o;
  logic        err_timeout_o;
  logic        dbg_state_o;

  int checks = 0;
  int errors = 0;

  ats21_cmd_arb #(.LO_TIMEOUT(LO_T)) dut (
    .clk_i(clk), .rst_ni(rst_n), .req_i(req), .ctrl_a_i(ctrl_a), .ctrl_b_i(ctrl_b),
    .ready_o(ready_o), .stat_o(stat_o), .cmd_valid_o(cmd_valid_o), .cmd_data_o(cmd_data_o),
    .cmd_src_o(cmd_src_o), .cmd_ready_i(cmd_ready), .err_illegal_o(err_illegal_o),
    .err_timeout_o(err_timeout_o), .dbg_state_o(dbg_state_o)
  );

  // clock / reset
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
    end
  endtask

  // model: ports indexed 0=A, 1=B
  bit          m_lo;
  logic [15:0] m_up[2];
  int          m_idle;
  bit          m_pend[2];
  bit          n_pend[2];
  logic [31:0] m_cmd[2];
  bit          m_iv;
  logic [31:0] m_id;
  int          m_is;
  int          m_tie_next;
  logic [1:0]  m_stat;
  logic [1:0]  m_ill;
  bit          m_to;
  int          pick;
  logic [31:0] w;
  bit          m_ready;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_lo = 0; m_idle = 0; m_iv = 0; m_id = 0; m_is = 0; m_tie_next = 0;
      m_stat = 0; m_ill = 0; m_to = 0;
      for (int p = 0; p < 2; p++) begin
        m_up[p] = 0; m_pend[p] = 0; m_cmd[p] = 0;
      end
    end else begin
      m_ready = m_lo || !(m_pend[0] || m_pend[1]);
      m_stat = (m_iv && cmd_ready) ? (2'b01 << m_is) : 2'b00;
      m_ill = 0;
      m_to = 0;
      n_pend = m_pend;
      if (!m_iv || cmd_ready) begin
        pick = -1;
        if (m_pend[0] && m_pend[1]) begin
          pick = m_tie_next;
          m_tie_next = 1 - pick;
        end else if (m_pend[0]) pick = 0;
        else if (m_pend[1]) pick = 1;
        if (pick >= 0) begin
          m_iv = 1; m_id = m_cmd[pick]; m_is = pick; n_pend[pick] = 0;
        end else begin
          m_iv = 0;
        end
      end
      if (!m_lo) begin
        if (req && m_ready) begin
          m_up[0] = ctrl_a; m_up[1] = ctrl_b; m_lo = 1; m_idle = 0;
        end
      end else if (req) begin
        m_lo = 0;
        for (int p = 0; p < 2; p++) begin
          w = {m_up[p], (p == 0) ? ctrl_a : ctrl_b};
          if (w[31:29] == 3'b100) m_ill[p] = 1'b1;
          else if (w[31:29] != 3'b000) begin
            n_pend[p] = 1; m_cmd[p] = w;
          end
        end
      end else begin
        m_idle++;
        if (m_idle == LO_T) begin
          m_lo = 0; m_to = 1; m_up[0] = 0; m_up[1] = 0;
        end
      end
      m_pend = n_pend;
    end
  end

  // per-cycle compare
  always @(negedge clk) begin
    chk("ready", ready_o, m_lo || !(m_pend[0] || m_pend[1]));
    chk("cmd_valid", cmd_valid_o, m_iv);
    if (m_iv) begin
      chk("cmd_data", cmd_data_o, m_id);
      chk("cmd_src", cmd_src_o, m_is[0]);
    end
    chk("stat", stat_o, m_stat);
    chk("err_illegal", err_illegal_o, m_ill);
    chk("err_timeout", err_timeout_o, m_to);
    chk("state", dbg_state_o, m_lo);
  end

  // driver tasks
  task automatic cyc(input logic r, input logic [15:0] a, input logic [15:0] b, input logic cr);
    @(negedge clk);
    req = r; ctrl_a = a; ctrl_b = b; cmd_ready = cr;
  endtask

  task automatic expect_issue(input string name, input logic [31:0] d, input logic s);
    bit seen;
    seen = 0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(posedge clk); #1;
      if (cmd_valid_o) seen = 1;
    end
    chk({name, "_seen"}, seen, 1);
    if (seen) begin
      chk({name, "_data"}, cmd_data_o, d);
      chk({name, "_src"}, cmd_src_o, s);
    end
  endtask

  initial begin
    #500000;
    errors++;
    $display("FAIL watchdog actual=running expected=finished t=%0t", $time);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    repeat (2) @(negedge clk);
    chk("rst_ready", ready_o, 1);
    chk("rst_valid", cmd_valid_o, 0);
    chk("rst_data", cmd_data_o, 0);
    chk("rst_stat", stat_o, 0);
    rst_n = 1'b1;

    // single A command
    cyc(1, 16'h2A00, 16'h0000, 1);
    cyc(1, 16'h0010, 16'h0000, 1);
    cyc(0, 16'h0000, 16'h0000, 1);
    expect_issue("single", 32'h2A00_0010, 0);
    @(posedge clk); #1;
    chk("single_stat", stat_o, 2'b01);
    chk("single_no_b", cmd_valid_o, 0);

    // two ties: round-robin flips the winner
    cyc(1, 16'h2200, 16'hE080, 1);
    cyc(1, 16'h0005, 16'h0000, 1);
    cyc(0, 16'h0000, 16'h0000, 1);
    expect_issue("tie1_a", 32'h2200_0005, 0);
    expect_issue("tie1_b", 32'hE080_0000, 1);
    cyc(0, 16'h0000, 16'h0000, 1);
    cyc(1, 16'h2200, 16'hE080, 1);
    cyc(1, 16'h0005, 16'h0000, 1);
    cyc(0, 16'h0000, 16'h0000, 1);
    expect_issue("tie2_b", 32'hE080_0000, 1);
    expect_issue("tie2_a", 32'h2200_0005, 0);
    repeat (2) cyc(0, 16'h0000, 16'h0000, 1);

    // backpressure with new req held high
    cyc(1, 16'h4000, 16'h6000, 0);
    cyc(1, 16'h1111, 16'h2222, 0);
    for (int i = 0; i < 5; i++) begin
      cyc(1, 16'h7777, 16'h7777, 0);
      @(posedge clk); #1;
      chk("bp_ready", ready_o, 0);
      chk("bp_valid", cmd_valid_o, 1);
      chk("bp_data", cmd_data_o, 32'h4000_1111);
    end
    cyc(0, 16'h0000, 16'h0000, 1);
    expect_issue("bp_b", 32'h6000_2222, 1);
    chk("bp_ready_back", ready_o, 1);
    repeat (2) cyc(0, 16'h0000, 16'h0000, 1);

    // illegal A, no-op B
    cyc(1, 16'h8000, 16'h0000, 1);
    cyc(1, 16'h0ABC, 16'h0DEF, 1);
    @(posedge clk); #1;
    chk("ill_pulse", err_illegal_o, 2'b01);
    chk("ill_valid", cmd_valid_o, 0);
    chk("ill_ready", ready_o, 1);
    cyc(0, 16'h0000, 16'h0000, 1);
    @(posedge clk); #1;
    chk("ill_clear", err_illegal_o, 2'b00);
    chk("ill_still_empty", cmd_valid_o, 0);

    // timeout, then a fresh upper beat
    cyc(1, 16'h2A00, 16'h0000, 1);
    repeat (LO_T) cyc(0, 16'h0000, 16'h0000, 1);
    @(posedge clk); #1;
    chk("to_pulse", err_timeout_o, 1);
    chk("to_state_hi", dbg_state_o, 0);
    cyc(1, 16'h3000, 16'h0000, 1);
    cyc(1, 16'h0001, 16'h0000, 1);
    cyc(0, 16'h0000, 16'h0000, 1);
    expect_issue("after_to", 32'h3000_0001, 0);

    // lower beat exactly at the timeout edge is honored
    cyc(1, 16'h5000, 16'h0000, 1);
    repeat (LO_T - 1) cyc(0, 16'h0000, 16'h0000, 1);
    cyc(1, 16'h0007, 16'h0000, 1);
    cyc(0, 16'h0000, 16'h0000, 1);
    chk("edge_no_to", err_timeout_o, 0);
    expect_issue("edge_lo", 32'h5000_0007, 0);
    repeat (2) cyc(0, 16'h0000, 16'h0000, 1);

    // async reset with cmd_valid=1 in LO
    cyc(1, 16'h2A00, 16'h0000, 0);
    cyc(1, 16'h0010, 16'h0000, 0);
    cyc(0, 16'h0000, 16'h0000, 0);
    cyc(0, 16'h0000, 16'h0000, 0);
    cyc(1, 16'h3000, 16'h0000, 0);
    cyc(0, 16'h0000, 16'h0000, 0);
    #2;
    chk("pre_rst_valid", cmd_valid_o, 1);
    chk("pre_rst_lo", dbg_state_o, 1);
    rst_n = 1'b0;
    #1;
    chk("arst_valid", cmd_valid_o, 0);
    chk("arst_data", cmd_data_o, 0);
    chk("arst_src", cmd_src_o, 0);
    chk("arst_ready", ready_o, 1);
    chk("arst_state", dbg_state_o, 0);
    chk("arst_stat", stat_o, 0);
    chk("arst_err", {29'd0, err_timeout_o, err_illegal_o}, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    cyc(1, 16'h2A00, 16'h0000, 1);
    cyc(1, 16'h0010, 16'h0000, 1);
    cyc(0, 16'h0000, 16'h0000, 1);
    expect_issue("post_rst", 32'h2A00_0010, 0);
    repeat (3) cyc(0, 16'h0000, 16'h0000, 1);
    @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
